// File: rtl/shift_reg_lr_load.sv
// Bidirectional shift register with parallel load, a shift-down counter and a drain pulse.
// Define SHIFT_REG_ROTATE_EN to refill the vacated bit with the bit shifted out (rotate).
module shift_reg_lr_load #(
   parameter int unsigned REG_WIDTH = 8,
   parameter int unsigned CNT_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 load,
   input  logic                 shift_left_right,
   input  logic                 shift_en,
   input  logic [REG_WIDTH-1:0] data_in,
   input  logic                 serial_in,
   output logic [REG_WIDTH-1:0] data_out,
   output logic                 serial_out,
   output logic [CNT_WIDTH-1:0] shift_count,
   output logic                 busy,
   output logic                 done
);

   localparam logic [CNT_WIDTH-1:0] LP_FULL_COUNT = CNT_WIDTH'(REG_WIDTH);
   localparam logic [CNT_WIDTH-1:0] LP_ONE        = CNT_WIDTH'(1);

   typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

   logic [REG_WIDTH-1:0] r_data;
   logic                 r_serial;
   logic [CNT_WIDTH-1:0] r_count;
   logic                 r_done;

   state_e               w_state;
   logic                 w_do_shift;
   logic                 w_shift_out;
   logic                 w_fill;
   logic [REG_WIDTH-1:0] w_shifted;

   // The state is fully encoded by the counter: nothing to shift means idle.
   assign w_state     = (r_count != '0) ? ST_ACTIVE : ST_IDLE;
   assign w_do_shift  = !load && shift_en && (w_state == ST_ACTIVE);
   assign w_shift_out = shift_left_right ? r_data[REG_WIDTH-1] : r_data[0];

`ifdef SHIFT_REG_ROTATE_EN
   logic w_unused_serial_in;
   assign w_unused_serial_in = serial_in;
   assign w_fill             = w_shift_out;
`else
   assign w_fill = serial_in;
`endif

   always_comb begin
      w_shifted = r_data;
      if (shift_left_right) begin
         w_shifted = {r_data[REG_WIDTH-2:0], w_fill};
      end else begin
         w_shifted = {w_fill, r_data[REG_WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data   <= '0;
         r_serial <= 1'b0;
         r_count  <= '0;
         r_done   <= 1'b0;
      end else if (load) begin
         r_data   <= data_in;
         r_serial <= 1'b0;
         r_count  <= LP_FULL_COUNT;
         r_done   <= 1'b0;
      end else if (w_do_shift) begin
         r_data   <= w_shifted;
         r_serial <= w_shift_out;
         r_count  <= r_count - LP_ONE;
         r_done   <= (r_count == LP_ONE);
      end else begin
         // Hold everything; done is a pulse, so it always falls back to 0.
         r_done   <= 1'b0;
      end
   end

   assign data_out    = r_data;
   assign serial_out  = r_serial;
   assign shift_count = r_count;
   assign busy        = (w_state == ST_ACTIVE);
   assign done        = r_done;

endmodule

// File: tb/tb_shift_reg_lr_load.sv
// Self-checking bench for shift_reg_lr_load: directed scenarios plus random traffic
// checked against an arithmetic reference model.
module tb_shift_reg_lr_load;

   localparam int W = 8;
   localparam int C = 4;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         load;
   logic         shift_left_right;
   logic         shift_en;
   logic [W-1:0] data_in;
   logic         serial_in;
   logic [W-1:0] data_out;
   logic         serial_out;
   logic [C-1:0] shift_count;
   logic         busy;
   logic         done;

   int errors = 0;
   int checks = 0;

   // Reference model state
   int unsigned m_data;
   int unsigned m_serial;
   int unsigned m_count;
   int unsigned m_done;

   shift_reg_lr_load #(.REG_WIDTH(W), .CNT_WIDTH(C)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .load             (load),
      .shift_left_right (shift_left_right),
      .shift_en         (shift_en),
      .data_in          (data_in),
      .serial_in        (serial_in),
      .data_out         (data_out),
      .serial_out       (serial_out),
      .shift_count      (shift_count),
      .busy             (busy),
      .done             (done)
   );

   always #5 clk = ~clk;

`ifdef SHIFT_REG_ROTATE_EN
   localparam bit ROTATE = 1'b1;
`else
   localparam bit ROTATE = 1'b0;
`endif

   // Register viewed as a number: left shift doubles it, right shift halves it.
   task automatic model_step();
      int unsigned out_bit, fill;
      if (load) begin
         m_data = data_in; m_count = W; m_serial = 0; m_done = 0;
      end else if (shift_en && m_count != 0) begin
         if (shift_left_right) begin
            out_bit = m_data / (2 ** (W - 1));
            fill    = ROTATE ? out_bit : serial_in;
            m_data  = (m_data * 2) % (2 ** W) + fill;
         end else begin
            out_bit = m_data % 2;
            fill    = ROTATE ? out_bit : serial_in;
            m_data  = m_data / 2 + fill * (2 ** (W - 1));
         end
         m_serial = out_bit;
         m_count  = m_count - 1;
         m_done   = (m_count == 0) ? 1 : 0;
      end else begin
         m_done = 0;
      end
   endtask

   task automatic model_reset();
      m_data = 0; m_serial = 0; m_count = 0; m_done = 0;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      load = 0; shift_en = 0; shift_left_right = 0; data_in = '0; serial_in = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset_n = 0;
      model_reset();
      #3;
      checks++;
      if ({data_out, serial_out, shift_count, busy, done} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got data=%h ser=%b cnt=%0d busy=%b done=%b want all 0",
                  data_out, serial_out, shift_count, busy, done);
      end
      @(posedge clk); #1;
      reset_n = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_left_shift();
      load = 1; data_in = 8'b1010_0101; tick();
      load = 0; shift_en = 1; shift_left_right = 1; serial_in = 0; tick();
      shift_en = 0;
      checks++;
      if (data_out !== (ROTATE ? 8'b0100_1011 : 8'b0100_1010)) begin
         errors++; $display("FAIL left_data got %b want %b", data_out, m_data[W-1:0]);
      end
      checks++;
      if (serial_out !== 1'b1) begin
         errors++; $display("FAIL left_serial got %b want 1", serial_out);
      end
      checks++;
      if (shift_count !== 4'd7) begin
         errors++; $display("FAIL left_count got %0d want 7", shift_count);
      end
   endtask

   task automatic test_right_shift();
      load = 1; data_in = 8'b0000_0001; tick();
      load = 0; shift_en = 1; shift_left_right = 0; serial_in = ROTATE ? 1'b0 : 1'b1; tick();
      shift_en = 0;
      checks++;
      if (data_out !== 8'b1000_0000) begin
         errors++; $display("FAIL right_data got %b want 10000000", data_out);
      end
      checks++;
      if (serial_out !== 1'b1) begin
         errors++; $display("FAIL right_serial got %b want 1", serial_out);
      end
   endtask

   task automatic test_load_priority();
      load = 1; shift_en = 1; shift_left_right = 1; serial_in = 1; data_in = 8'hC3; tick();
      load = 0; shift_en = 0;
      checks++;
      if (data_out !== 8'hC3) begin
         errors++; $display("FAIL prio_data got %h want c3", data_out);
      end
      checks++;
      if (shift_count !== 4'd8 || busy !== 1'b1) begin
         errors++; $display("FAIL prio_count got cnt=%0d busy=%b want 8/1", shift_count, busy);
      end
   endtask

   task automatic test_drain();
      int done_seen = 0;
      load = 1; data_in = 8'hFF; tick();
      load = 0; shift_en = 1; shift_left_right = 1; serial_in = 0;
      for (int i = 0; i < W; i++) begin
         tick();
         if (done === 1'b1) done_seen++;
      end
      checks++;
      if (data_out !== (ROTATE ? 8'hFF : 8'h00) || shift_count !== 4'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL drain_state got data=%h cnt=%0d busy=%b want %h/0/0",
                  data_out, shift_count, busy, m_data[W-1:0]);
      end
      checks++;
      if (done !== 1'b1 || done_seen != 1) begin
         errors++; $display("FAIL drain_done got done=%b pulses=%0d want 1/1", done, done_seen);
      end
      serial_in = 1; tick();
      shift_en = 0;
      checks++;
      if (done !== 1'b0 || shift_count !== 4'd0 || data_out !== m_data[W-1:0]) begin
         errors++;
         $display("FAIL ninth_shift got done=%b cnt=%0d data=%h want 0/0/%h",
                  done, shift_count, data_out, m_data[W-1:0]);
      end
   endtask

   task automatic test_reload();
      int done_seen = 0;
      load = 1; data_in = $urandom; tick();
      load = 0; shift_en = 1; shift_left_right = 0;
      for (int i = 0; i < 5; i++) tick();
      shift_en = 0;
      checks++;
      if (shift_count !== 4'd3) begin
         errors++; $display("FAIL reload_pre got %0d want 3", shift_count);
      end
      load = 1; shift_en = 1; data_in = 8'h5A; tick();
      if (done === 1'b1) done_seen++;
      load = 0; shift_en = 0; tick();
      if (done === 1'b1) done_seen++;
      checks++;
      if (data_out !== 8'h5A || shift_count !== 4'd8 || done_seen != 0) begin
         errors++;
         $display("FAIL reload got data=%h cnt=%0d pulses=%0d want 5a/8/0",
                  data_out, shift_count, done_seen);
      end
   endtask

   task automatic test_reset_mid();
      int done_seen = 0;
      load = 1; data_in = 8'h3C; tick();
      load = 0; shift_en = 1; shift_left_right = 1; serial_in = 1;
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (shift_count !== 4'd5) begin
         errors++; $display("FAIL midreset_pre got %0d want 5", shift_count);
      end
      #2 reset_n = 0;
      model_reset();
      #1;
      checks++;
      if ({data_out, serial_out, shift_count, busy, done} !== '0) begin
         errors++;
         $display("FAIL midreset_async got data=%h ser=%b cnt=%0d busy=%b done=%b want all 0",
                  data_out, serial_out, shift_count, busy, done);
      end
      @(posedge clk); #1;
      reset_n = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (done === 1'b1) done_seen++;
      end
      shift_en = 0;
      checks++;
      if (done_seen != 0 || shift_count !== 4'd0 || data_out !== 8'h00) begin
         errors++;
         $display("FAIL midreset_after got pulses=%0d cnt=%0d data=%h want 0/0/00",
                  done_seen, shift_count, data_out);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         load             = ($urandom_range(0, 9) == 0);
         shift_en         = ($urandom_range(0, 3) != 0);
         shift_left_right = $urandom;
         serial_in        = $urandom;
         data_in          = $urandom;
         tick();
         checks++;
         if (data_out !== m_data[W-1:0] || serial_out !== m_serial[0] ||
             shift_count !== m_count[C-1:0] || busy !== (m_count != 0) ||
             done !== m_done[0]) begin
            errors++;
            $display("FAIL random[%0d] got data=%h ser=%b cnt=%0d busy=%b done=%b want %h/%0d/%0d/%0d/%0d",
                     i, data_out, serial_out, shift_count, busy, done,
                     m_data[W-1:0], m_serial, m_count, (m_count != 0), m_done);
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_left_shift();
      test_right_shift();
      test_load_priority();
      test_drain();
      test_reload();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shift_reg_lr_load.md
SHIFT_REG_LR_LOAD -- requirements
Module: shift_reg_lr_load

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 8, register width in bits (>= 2).
REQ-002 SHALL have parameter CNT_WIDTH, default 4, shift-counter width; 2**CNT_WIDTH > REG_WIDTH required.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on posedge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port load  input  1  parallel load request.
REQ-006 SHALL have port shift_left_right  input  1  shift direction: 1 = left (toward MSB), 0 = right (toward LSB).
REQ-007 SHALL have port shift_en  input  1  shift request, honoured only when load = 0.
REQ-008 SHALL have port data_in  input  REG_WIDTH  parallel load value.
REQ-009 SHALL have port serial_in  input  1  fill bit for the vacated position (non-rotate build).
REQ-010 SHALL have port data_out  output  REG_WIDTH  registered register contents.
REQ-011 SHALL have port serial_out  output  1  registered bit shifted out by the most recent shift.
REQ-012 SHALL have port shift_count  output  CNT_WIDTH  remaining shifts before drain.
REQ-013 SHALL have port busy  output  1  high while shift_count != 0.
REQ-014 SHALL have port done  output  1  registered one-cycle pulse when the register drains.

Function
REQ-015 SHALL implement two states: IDLE (shift_count = 0) and ACTIVE (shift_count != 0); busy SHALL be 1 exactly in ACTIVE.
REQ-016 SHALL, on posedge with load = 1, set data_out = data_in, shift_count = REG_WIDTH, serial_out = 0, done = 0, and enter ACTIVE, in any state.
REQ-017 SHALL give load priority: load = 1 with shift_en = 1 performs only the load.
REQ-018 SHALL, on posedge with load = 0, shift_en = 1, state ACTIVE, shift left when shift_left_right = 1: data_out <= {data_out[REG_WIDTH-2:0], fill}, serial_out <= old data_out[REG_WIDTH-1].
REQ-019 SHALL, same conditions with shift_left_right = 0, shift right: data_out <= {fill, data_out[REG_WIDTH-1:1]}, serial_out <= old data_out[0].
REQ-020 SHALL decrement shift_count by 1 on every performed shift; no wrap below 0.
REQ-021 SHALL assert done for exactly the one cycle following the shift that moves shift_count from 1 to 0, then return to IDLE.
REQ-022 SHALL ignore shift_en in IDLE: data_out, serial_out, shift_count unchanged, done stays 0.
REQ-023 SHALL hold all state when load = 0 and shift_en = 0, in either state.
REQ-024 SHALL allow direction to change on any cycle; each shift uses shift_left_right sampled at that posedge.
REQ-025 SHALL have single-cycle latency: effects of load/shift visible on outputs immediately after the sampling posedge.

Reset
REQ-026 SHALL, while reset_n = 0, asynchronously force data_out = 0, serial_out = 0, shift_count = 0, done = 0, busy = 0 (IDLE).
REQ-027 SHALL, on reset mid-operation, abandon the sequence with no done pulse; the first posedge after release obeys REQ-016..023.

Configuration
REQ-028 SHALL, when macro SHIFT_REG_ROTATE_EN is defined, use fill = bit shifted out (rotate) and ignore serial_in.
REQ-029 SHALL, when SHIFT_REG_ROTATE_EN is undefined, use fill = serial_in; no other behaviour differs between builds.

Verification (REG_WIDTH = 8, CNT_WIDTH = 4)
REQ-030 SHALL cover: reset_n low mid-ACTIVE (count 5) -> data_out 0, serial_out 0, shift_count 0, busy 0, no done pulse, without waiting for clk.
REQ-031 SHALL cover: load 8'b1010_0101, then one left shift, serial_in = 0 -> data_out 8'b0100_1010, serial_out 1, shift_count 7 (rotate build: 8'b0100_1011).
REQ-032 SHALL cover: load 8'b0000_0001, one right shift, serial_in = 1 -> data_out 8'b1000_0000, serial_out 1 (rotate build: same data_out, serial_in ignored when set 0).
REQ-033 SHALL cover: load = 1, shift_en = 1, data_in 8'hC3 same cycle -> data_out 8'hC3, shift_count 8, no shift.
REQ-034 SHALL cover: load 8'hFF then 8 left shifts, serial_in = 0 -> data_out 0, done high exactly one cycle, busy 0; 9th shift_en ignored.
REQ-035 SHALL cover: reload data_in 8'h5A at shift_count 3 -> data_out 8'h5A, shift_count 8, no done pulse.
